// File: rtl/hpdc_mem_rd_arbiter.sv
// HPDCache memory read-channel arbiter: round-robin request grant with lock, requester index in TID MSBs,
// 1-entry response register routing beats back, and per-requester outstanding read tracking.
package hpdc_mem_rd_arbiter_pkg;
    localparam int HPDCACHE_MEM_TID_WIDTH = 8;

    typedef struct packed {
        logic [31:0]                       mem_req_addr;
        logic [7:0]                        mem_req_len;
        logic [2:0]                        mem_req_size;
        logic [HPDCACHE_MEM_TID_WIDTH-1:0] mem_req_id;
        logic                              mem_req_cacheable;
    } mem_req_t;

    typedef struct packed {
        logic [1:0]                        mem_resp_r_error;
        logic [HPDCACHE_MEM_TID_WIDTH-1:0] mem_resp_r_id;
        logic [63:0]                       mem_resp_r_data;
        logic                              mem_resp_r_last;
    } mem_resp_r_t;
endpackage

module hpdc_mem_rd_arbiter
    import hpdc_mem_rd_arbiter_pkg::*;
#(
    parameter int NREQ      = 2,
    parameter int TID_W     = HPDCACHE_MEM_TID_WIDTH,
    parameter int MAX_OUTST = 4,
    localparam int IDX_W    = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic [NREQ-1:0]   req_valid_i,
    output logic [NREQ-1:0]   req_ready_o,
    input  mem_req_t          req_i [NREQ],
    output logic [NREQ-1:0]   resp_valid_o,
    input  logic [NREQ-1:0]   resp_ready_i,
    output mem_resp_r_t       resp_o,
    output logic              mem_req_valid_o,
    input  logic              mem_req_ready_i,
    output mem_req_t          mem_req_o,
    input  logic              mem_resp_valid_i,
    output logic              mem_resp_ready_o,
    input  mem_resp_r_t       mem_resp_i,
    output logic [3:0]        outst_o [NREQ],
    output logic              err_o
);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0] lock_idx_q, lock_idx_d;
    logic [NREQ-1:0]  eligible;
    logic [IDX_W-1:0] cand;
    logic             gnt_valid;
    logic [IDX_W-1:0] gnt_idx;
    logic             req_hs;

    logic             resp_full_q, resp_full_d;
    mem_resp_r_t      resp_q, resp_d;
    logic [IDX_W-1:0] dst_q, dst_d;
    logic [IDX_W-1:0] beat_dst;
    logic             beat_dst_ok;
    logic             beat_acc;

    logic [3:0]       outst_q [NREQ];
    logic [3:0]       outst_d [NREQ];
    logic [NREQ-1:0]  inc_v, dec_v;
    logic             err_q, err_d;

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            eligible[i] = req_valid_i[i] && (outst_q[i] < 4'(MAX_OUTST));
        end
    end

    // Walk offsets from highest to lowest so the nearest eligible requester at or after rr_ptr wins.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = rr_ptr_q;
        cand      = rr_ptr_q;
        if (state_q == ST_LOCKED) begin
            gnt_valid = 1'b1;
            gnt_idx   = lock_idx_q;
        end else begin
            for (int k = NREQ - 1; k >= 0; k--) begin
                cand = IDX_W'((int'(rr_ptr_q) + k) % NREQ);
                if (eligible[cand]) begin
                    gnt_valid = 1'b1;
                    gnt_idx   = cand;
                end
            end
        end
    end

    assign req_hs          = gnt_valid && mem_req_ready_i;
    assign mem_req_valid_o = gnt_valid;

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            req_ready_o[i] = mem_req_ready_i && gnt_valid && (gnt_idx == IDX_W'(i));
        end
    end

    always_comb begin
        mem_req_o = req_i[gnt_idx];
        mem_req_o.mem_req_id[TID_W-1 -: IDX_W] = gnt_idx;
    end

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        lock_idx_d = lock_idx_q;
        if (gnt_valid) begin
            if (mem_req_ready_i) begin
                state_d  = ST_IDLE;
                rr_ptr_d = IDX_W'((int'(gnt_idx) + 1) % NREQ);
            end else begin
                state_d    = ST_LOCKED;
                lock_idx_d = gnt_idx;
            end
        end
    end

    assign beat_dst         = mem_resp_i.mem_resp_r_id[TID_W-1 -: IDX_W];
    assign beat_dst_ok      = int'(beat_dst) < NREQ;
    assign mem_resp_ready_o = !resp_full_q || resp_ready_i[dst_q];
    assign beat_acc         = mem_resp_valid_i && mem_resp_ready_o;
    assign resp_o           = resp_q;

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            resp_valid_o[i] = resp_full_q && (dst_q == IDX_W'(i));
        end
    end

    // A beat loading in the same cycle as the consumer drains the register keeps it full.
    always_comb begin
        resp_full_d = resp_full_q;
        resp_d      = resp_q;
        dst_d       = dst_q;
        if (resp_full_q && resp_ready_i[dst_q]) begin
            resp_full_d = 1'b0;
        end
        if (beat_acc && beat_dst_ok) begin
            resp_full_d = 1'b1;
            resp_d      = mem_resp_i;
            resp_d.mem_resp_r_id[TID_W-1 -: IDX_W] = '0;
            dst_d       = beat_dst;
        end
    end

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            inc_v[i] = req_hs && (gnt_idx == IDX_W'(i));
            dec_v[i] = beat_acc && beat_dst_ok && mem_resp_i.mem_resp_r_last && (beat_dst == IDX_W'(i));
        end
    end

    always_comb begin
        err_d = err_q;
        if (beat_acc && !beat_dst_ok) begin
            err_d = 1'b1;
        end
        for (int i = 0; i < NREQ; i++) begin
            outst_d[i] = outst_q[i];
            if (dec_v[i] && (outst_q[i] == 4'd0)) begin
                err_d = 1'b1;
            end
            if (inc_v[i] && !dec_v[i]) begin
                outst_d[i] = outst_q[i] + 4'd1;
            end else if (dec_v[i] && !inc_v[i] && (outst_q[i] != 4'd0)) begin
                outst_d[i] = outst_q[i] - 4'd1;
            end
        end
    end

    assign outst_o = outst_q;
    assign err_o   = err_q;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= '0;
            lock_idx_q  <= '0;
            resp_full_q <= 1'b0;
            resp_q      <= '0;
            dst_q       <= '0;
            err_q       <= 1'b0;
            for (int i = 0; i < NREQ; i++) begin
                outst_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            lock_idx_q  <= lock_idx_d;
            resp_full_q <= resp_full_d;
            resp_q      <= resp_d;
            dst_q       <= dst_d;
            err_q       <= err_d;
            for (int i = 0; i < NREQ; i++) begin
                outst_q[i] <= outst_d[i];
            end
        end
    end

    // Requesters must keep valid up while locked and leave the TID index bits clear.
    a_hold_valid: assert property (@(posedge clk_i) disable iff (!rstn_i)
        (state_q == ST_LOCKED) |-> req_valid_i[lock_idx_q]);
    a_tid_clean: assert property (@(posedge clk_i) disable iff (!rstn_i)
        gnt_valid |-> (req_i[gnt_idx].mem_req_id[TID_W-1 -: IDX_W] == '0));
    a_one_ready: assert property (@(posedge clk_i) disable iff (!rstn_i)
        $onehot0(req_ready_o));

endmodule

// File: tb/tb_hpdc_mem_rd_arbiter.sv
// Self-checking bench for hpdc_mem_rd_arbiter: vector table for arbitration, hand sequences for
// locking, outstanding limits and response routing, with a response scoreboard.
module tb_hpdc_mem_rd_arbiter;
    import hpdc_mem_rd_arbiter_pkg::*;

    logic        clk_i = 1'b0;
    logic        rstn_i;
    logic [1:0]  req_valid_i, req_ready_o, resp_valid_o, resp_ready_i;
    mem_req_t    req_i [2];
    mem_req_t    mem_req_o;
    mem_resp_r_t resp_o, mem_resp_i;
    logic        mem_req_valid_o, mem_req_ready_i, mem_resp_valid_i, mem_resp_ready_o, err_o;
    logic [3:0]  outst_o [2];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        int          dst;
        logic [7:0]  id;
        logic [63:0] data;
        logic        last;
        int          expCyc;
    } exp_t;
    exp_t sbq[$];

    typedef struct {
        logic [1:0] valid;
        logic       memRdy;
        logic       expMemValid;
        logic [1:0] expReady;
        logic       chkTid;
        logic [7:0] expTid;
    } vec_t;
    vec_t vecs [11];

    hpdc_mem_rd_arbiter #(.NREQ(2), .TID_W(8), .MAX_OUTST(4)) dut (
        .clk_i            (clk_i),
        .rstn_i           (rstn_i),
        .req_valid_i      (req_valid_i),
        .req_ready_o      (req_ready_o),
        .req_i            (req_i),
        .resp_valid_o     (resp_valid_o),
        .resp_ready_i     (resp_ready_i),
        .resp_o           (resp_o),
        .mem_req_valid_o  (mem_req_valid_o),
        .mem_req_ready_i  (mem_req_ready_i),
        .mem_req_o        (mem_req_o),
        .mem_resp_valid_i (mem_resp_valid_i),
        .mem_resp_ready_o (mem_resp_ready_o),
        .mem_resp_i       (mem_resp_i),
        .outst_o          (outst_o),
        .err_o            (err_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic applyStimulus(input logic [1:0] valid, input logic memRdy);
        req_valid_i     = valid;
        mem_req_ready_i = memRdy;
    endtask

    task automatic doReset();
        tick();
        tick();
        rstn_i           = 1'b0;
        req_valid_i      = 2'b00;
        mem_req_ready_i  = 1'b1;
        mem_resp_valid_i = 1'b0;
        mem_resp_i       = '0;
        resp_ready_i     = 2'b11;
        tick();
        tick();
        rstn_i = 1'b1;
    endtask

    // Present a beat until accepted (bounded), then queue the routed response the requester should see.
    task automatic driveBeat(input logic [7:0] id, input logic [63:0] data, input logic last, input bit chkLat);
        int  c;
        bit  ok;
        exp_t e;
        ok = 1'b0;
        c  = 0;
        mem_resp_valid_i = 1'b1;
        mem_resp_i = '{mem_resp_r_error: 2'b00, mem_resp_r_id: id, mem_resp_r_data: data, mem_resp_r_last: last};
        for (int w = 0; w < 20 && !ok; w++) begin
            @(negedge clk_i);
            if (mem_resp_ready_o) begin
                ok = 1'b1;
                c  = cyc;
            end
            tick();
        end
        mem_resp_valid_i = 1'b0;
        checkOutput("beat_accept", 64'(ok), 64'd1);
        if (ok) begin
            e = '{dst: int'(id[7]), id: id & 8'h7F, data: data, last: last, expCyc: chkLat ? c + 1 : -1};
            sbq.push_back(e);
        end
    endtask

    always @(negedge clk_i) begin
        if (rstn_i === 1'b1) begin
            for (int i = 0; i < 2; i++) begin
                if (resp_valid_o[i] && resp_ready_i[i]) begin
                    if (sbq.size() == 0) begin
                        checkOutput($sformatf("resp_unexpected_%0d", i), 64'd1, 64'd0);
                    end else begin
                        exp_t e;
                        e = sbq.pop_front();
                        checkOutput("resp_dst", 64'(i), 64'(e.dst));
                        checkOutput("resp_id", 64'(resp_o.mem_resp_r_id), 64'(e.id));
                        checkOutput("resp_data", resp_o.mem_resp_r_data, e.data);
                        checkOutput("resp_last", 64'(resp_o.mem_resp_r_last), 64'(e.last));
                        if (e.expCyc >= 0) checkOutput("resp_latency", 64'(cyc), 64'(e.expCyc));
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        req_i[0] = '{mem_req_addr: 32'h1000, mem_req_len: 8'd0, mem_req_size: 3'd3, mem_req_id: 8'h03, mem_req_cacheable: 1'b1};
        req_i[1] = '{mem_req_addr: 32'h2000, mem_req_len: 8'd0, mem_req_size: 3'd3, mem_req_id: 8'h05, mem_req_cacheable: 1'b1};
        vecs[0]  = '{2'b11, 1'b1, 1'b1, 2'b01, 1'b1, 8'h03};
        vecs[1]  = '{2'b11, 1'b1, 1'b1, 2'b10, 1'b1, 8'h85};
        vecs[2]  = '{2'b11, 1'b1, 1'b1, 2'b01, 1'b1, 8'h03};
        vecs[3]  = '{2'b11, 1'b1, 1'b1, 2'b10, 1'b1, 8'h85};
        vecs[4]  = '{2'b10, 1'b1, 1'b1, 2'b10, 1'b1, 8'h85};
        vecs[5]  = '{2'b00, 1'b1, 1'b0, 2'b00, 1'b0, 8'h00};
        vecs[6]  = '{2'b01, 1'b1, 1'b1, 2'b01, 1'b1, 8'h03};
        vecs[7]  = '{2'b01, 1'b0, 1'b1, 2'b00, 1'b1, 8'h03};
        vecs[8]  = '{2'b11, 1'b1, 1'b1, 2'b01, 1'b1, 8'h03};
        vecs[9]  = '{2'b11, 1'b1, 1'b1, 2'b10, 1'b1, 8'h85};
        vecs[10] = '{2'b11, 1'b1, 1'b0, 2'b00, 1'b0, 8'h00};

        doReset();
        rstn_i = 1'b0;
        @(negedge clk_i);
        checkOutput("rst_mem_valid", 64'(mem_req_valid_o), 64'd0);
        checkOutput("rst_req_ready", 64'(req_ready_o), 64'd0);
        checkOutput("rst_resp_valid", 64'(resp_valid_o), 64'd0);
        checkOutput("rst_outst0", 64'(outst_o[0]), 64'd0);
        checkOutput("rst_outst1", 64'(outst_o[1]), 64'd0);
        checkOutput("rst_err", 64'(err_o), 64'd0);
        tick();
        rstn_i = 1'b1;

        // Arbitration table: alternation, lock against rr_ptr, and both requesters at the limit.
        for (int v = 0; v < 11; v++) begin
            applyStimulus(vecs[v].valid, vecs[v].memRdy);
            @(negedge clk_i);
            checkOutput($sformatf("t1_v%0d_mvalid", v), 64'(mem_req_valid_o), 64'(vecs[v].expMemValid));
            checkOutput($sformatf("t1_v%0d_ready", v), 64'(req_ready_o), 64'(vecs[v].expReady));
            if (vecs[v].chkTid) checkOutput($sformatf("t1_v%0d_tid", v), 64'(mem_req_o.mem_req_id), 64'(vecs[v].expTid));
            tick();
        end
        checkOutput("t1_outst0", 64'(outst_o[0]), 64'd4);
        checkOutput("t1_outst1", 64'(outst_o[1]), 64'd4);

        // Grant lock while memory stalls.
        doReset();
        for (int c = 0; c < 5; c++) begin
            applyStimulus((c == 0) ? 2'b01 : 2'b11, c >= 3);
            @(negedge clk_i);
            checkOutput($sformatf("t2_c%0d_mvalid", c), 64'(mem_req_valid_o), 64'd1);
            checkOutput($sformatf("t2_c%0d_ready", c), 64'(req_ready_o), (c < 3) ? 64'd0 : ((c == 3) ? 64'd1 : 64'd2));
            checkOutput($sformatf("t2_c%0d_tid", c), 64'(mem_req_o.mem_req_id), (c < 4) ? 64'h03 : 64'h85);
            checkOutput($sformatf("t2_c%0d_addr", c), 64'(mem_req_o.mem_req_addr), (c < 4) ? 64'h1000 : 64'h2000);
            tick();
        end
        applyStimulus(2'b00, 1'b1);

        // Outstanding limit on requester 0.
        doReset();
        for (int c = 0; c < 4; c++) begin
            applyStimulus(2'b01, 1'b1);
            @(negedge clk_i);
            checkOutput($sformatf("t3_req%0d_ready", c), 64'(req_ready_o), 64'd1);
            tick();
        end
        checkOutput("t3_outst0_full", 64'(outst_o[0]), 64'd4);
        for (int c = 0; c < 2; c++) begin
            applyStimulus(2'b11, 1'b1);
            @(negedge clk_i);
            checkOutput($sformatf("t3_blk%0d_ready", c), 64'(req_ready_o), 64'd2);
            checkOutput($sformatf("t3_blk%0d_tid", c), 64'(mem_req_o.mem_req_id), 64'h85);
            tick();
        end
        applyStimulus(2'b00, 1'b1);
        checkOutput("t3_outst1", 64'(outst_o[1]), 64'd2);
        driveBeat(8'h02, 64'h1111_2222, 1'b1, 1'b1);
        checkOutput("t3_outst0_dec", 64'(outst_o[0]), 64'd3);

        // Backpressured response holds the register and blocks the next beat.
        doReset();
        applyStimulus(2'b10, 1'b1);
        tick();
        applyStimulus(2'b00, 1'b1);
        checkOutput("t4_outst1", 64'(outst_o[1]), 64'd1);
        resp_ready_i = 2'b01;
        driveBeat(8'h85, 64'h55, 1'b1, 1'b0);
        checkOutput("t4_outst1_dec", 64'(outst_o[1]), 64'd0);
        mem_resp_valid_i = 1'b1;
        mem_resp_i = '{mem_resp_r_error: 2'b00, mem_resp_r_id: 8'h01, mem_resp_r_data: 64'h66, mem_resp_r_last: 1'b0};
        for (int c = 0; c < 2; c++) begin
            @(negedge clk_i);
            checkOutput($sformatf("t4_hold%0d_valid", c), 64'(resp_valid_o), 64'd2);
            checkOutput($sformatf("t4_hold%0d_mrdy", c), 64'(mem_resp_ready_o), 64'd0);
            checkOutput($sformatf("t4_hold%0d_id", c), 64'(resp_o.mem_resp_r_id), 64'h05);
            tick();
        end
        resp_ready_i = 2'b11;
        driveBeat(8'h01, 64'h66, 1'b0, 1'b1);
        checkOutput("t4_err", 64'(err_o), 64'd0);

        // Burst for requester 0 at full throughput.
        doReset();
        applyStimulus(2'b01, 1'b1);
        tick();
        applyStimulus(2'b00, 1'b1);
        for (int b = 0; b < 8; b++) begin
            driveBeat(8'h07, 64'hA0 + 64'(b), b == 7, 1'b1);
            checkOutput($sformatf("t5_b%0d_outst0", b), 64'(outst_o[0]), (b < 7) ? 64'd1 : 64'd0);
        end

        // Spurious last beat sets the sticky error; coincident inc/dec leaves the count alone.
        doReset();
        driveBeat(8'h91, 64'h77, 1'b1, 1'b1);
        checkOutput("t6_err", 64'(err_o), 64'd1);
        checkOutput("t6_outst1", 64'(outst_o[1]), 64'd0);
        tick();
        tick();
        checkOutput("t6_err_sticky", 64'(err_o), 64'd1);
        applyStimulus(2'b01, 1'b1);
        tick();
        applyStimulus(2'b00, 1'b1);
        checkOutput("t6_outst0_one", 64'(outst_o[0]), 64'd1);
        applyStimulus(2'b01, 1'b1);
        driveBeat(8'h04, 64'h88, 1'b1, 1'b1);
        applyStimulus(2'b00, 1'b1);
        checkOutput("t6_outst0_same", 64'(outst_o[0]), 64'd1);
        driveBeat(8'h04, 64'h99, 1'b1, 1'b1);
        checkOutput("t6_outst0_zero", 64'(outst_o[0]), 64'd0);
        tick();
        tick();
        rstn_i = 1'b0;
        @(negedge clk_i);
        checkOutput("t6_err_reset", 64'(err_o), 64'd0);
        tick();
        rstn_i = 1'b1;

        checkOutput("sb_empty", 64'(sbq.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
